// File: rtl/rvdff_share_arb.sv
// Round-robin arbitrated loader for one shared WIDTH-bit staging register with valid/ready output.
// Optional RV_DFF_ARB_LOCK_EN adds io_req_lock so a requester can hold top priority across beats.
module rvdff_share_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned SW   = $clog2(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       io_req_valid,
   input  logic [NREQ*WIDTH-1:0] io_req_data,
   output logic [NREQ-1:0]       io_req_ready,
   output logic                  io_out_valid,
   output logic [WIDTH-1:0]      io_out_data,
   output logic [SW-1:0]         io_out_src,
   input  logic                  io_out_ready,
   output logic                  io_busy
`ifdef RV_DFF_ARB_LOCK_EN
   ,
   input  logic [NREQ-1:0]       io_req_lock
`endif
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e           state_q;
   logic [SW-1:0]    ptr_q;
   logic [SW-1:0]    ptr_d;
   logic [WIDTH-1:0] data_q;
   logic [SW-1:0]    src_q;

   logic [WIDTH-1:0] req_d [NREQ];
   logic             can_load;
   logic             gnt_any;
   logic [SW-1:0]    gnt_idx;
   logic [SW-1:0]    idx_s;
   int unsigned      idx;
   logic             xfer;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_d[g] = io_req_data[g*WIDTH +: WIDTH];
   end

   assign can_load = (state_q == EMPTY) || io_out_ready;

   // First valid requester at or after ptr_q, wrapping modulo NREQ.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      idx_s   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx   = (32'(ptr_q) + k) % NREQ;
         idx_s = idx[SW-1:0];
         if (!gnt_any && io_req_valid[idx_s]) begin
            gnt_any = 1'b1;
            gnt_idx = idx_s;
         end
      end
   end

   assign xfer = can_load && gnt_any;

   always_comb begin
      io_req_ready = '0;
      if (xfer) io_req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = (gnt_idx == SW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef RV_DFF_ARB_LOCK_EN
      if (io_req_lock[gnt_idx]) ptr_d = gnt_idx;
`endif
   end

   // Data flops are written only on a transfer; a bare consume just clears full.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
      end else if (xfer) begin
         state_q <= FULL;
         ptr_q   <= ptr_d;
         data_q  <= req_d[gnt_idx];
         src_q   <= gnt_idx;
      end else if (state_q == FULL && io_out_ready) begin
         state_q <= EMPTY;
      end
   end

   assign io_out_valid = (state_q == FULL);
   assign io_busy      = (state_q == FULL);
   assign io_out_data  = data_q;
   assign io_out_src   = src_q;

endmodule

// File: tb/tb_rvdff_share_arb.sv
// Randomized and directed bench for rvdff_share_arb against a priority-search reference model.
module tb_rvdff_share_arb;
   localparam int NREQ  = 4;
   localparam int WIDTH = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   v   = '0;
   logic [NREQ*WIDTH-1:0] d = '0;
   logic              ord = 1'b0;
`ifdef RV_DFF_ARB_LOCK_EN
   logic [NREQ-1:0]   lk  = '0;
`endif

   logic [NREQ-1:0]   io_req_ready;
   logic              io_out_valid;
   logic [WIDTH-1:0]  io_out_data;
   logic [1:0]        io_out_src;
   logic              io_busy;

   rvdff_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clock        (clk),
      .reset        (rst),
      .io_req_valid (v),
      .io_req_data  (d),
      .io_req_ready (io_req_ready),
      .io_out_valid (io_out_valid),
      .io_out_data  (io_out_data),
      .io_out_src   (io_out_src),
      .io_out_ready (ord),
      .io_busy      (io_busy)
`ifdef RV_DFF_ARB_LOCK_EN
      ,
      .io_req_lock  (lk)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] rd [NREQ];
   // Reference model: abstract register contents plus priority pointer.
   bit               m_full = 0;
   logic [WIDTH-1:0] m_data = '0;
   int               m_src  = 0;
   int               m_ptr  = 0;
   int               g_last = -1;

   logic [NREQ-1:0]  s_ready;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic [1:0]       s_src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] vv, input logic o);
      if (m_full && !o) return -1;
      for (int k = 0; k < NREQ; k++)
         if (vv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic cyc(input logic r, input logic [NREQ-1:0] vv, input logic o);
      int  g;
      bit  lock_eff;
      logic [NREQ-1:0] er;
      @(negedge clk);
      rst = r; v = vv; ord = o;
      for (int k = 0; k < NREQ; k++) d[k*WIDTH +: WIDTH] = rd[k];
      #1;
      g  = pick(vv, o);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(io_req_ready), 32'(er));
      chk("out_valid", 32'(io_out_valid), 32'(m_full));
      chk("busy",      32'(io_busy),      32'(m_full));
      chk("out_data",  32'(io_out_data),  32'(m_data));
      chk("out_src",   32'(io_out_src),   32'(m_src));
      s_ready = io_req_ready; s_valid = io_out_valid; s_data = io_out_data; s_src = io_out_src;
      @(posedge clk);
      lock_eff = 1'b0;
`ifdef RV_DFF_ARB_LOCK_EN
      if (g >= 0) lock_eff = lk[g];
`endif
      if (r) begin
         m_full = 0; m_data = '0; m_src = 0; m_ptr = 0; g_last = -1;
      end else if (g >= 0) begin
         m_data = rd[g]; m_src = g; m_full = 1;
         m_ptr  = lock_eff ? g : (g + 1) % NREQ;
         g_last = g;
      end else begin
         if (m_full && o) m_full = 0;
         g_last = -1;
      end
   endtask

   initial begin
      for (int k = 0; k < NREQ; k++) rd[k] = 16'(16'h1000 * (k + 1) + k);

      // Reset two cycles, then idle.
      cyc(1, 4'b0000, 0);
      cyc(1, 4'b0000, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'b0000, 0);
         chk("idle_valid", 32'(s_valid), 0);
         chk("idle_ready", 32'(s_ready), 0);
         chk("idle_data",  32'(s_data),  0);
      end

      // Single beat from requester 2 with backpressure.
      rd[2] = 16'hA5A5;
      cyc(0, 4'b0100, 0);
      chk("single_gnt", 32'(s_ready), 32'h4);
      cyc(0, 4'b0100, 0);
      chk("single_valid", 32'(s_valid), 1);
      chk("single_data",  32'(s_data),  32'hA5A5);
      chk("single_src",   32'(s_src),   2);
      chk("single_hold",  32'(s_ready), 0);
      cyc(0, 4'b0000, 1);
      cyc(0, 4'b0000, 0);
      chk("single_drain", 32'(s_valid), 0);

      // Round-robin wrap, all requesters valid, consumer always ready.
      cyc(1, 4'b0000, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 4'b1111, 1);
         chk("rr_gnt", 32'(s_ready), 32'(4'b0001 << (i % 4)));
         if (i > 0) chk("rr_src", 32'(s_src), 32'((i - 1) % 4));
      end

      // Backpressure with src=1, then simultaneous consume and reload from 3.
      rd[1] = 16'h1111; rd[3] = 16'h3333;
      cyc(0, 4'b0010, 1);
      chk("bp_load", 32'(s_ready), 32'h2);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'b1000, 0);
         chk("bp_ready", 32'(s_ready), 0);
         chk("bp_data",  32'(s_data),  32'h1111);
         chk("bp_src",   32'(s_src),   1);
      end
      cyc(0, 4'b1000, 1);
      chk("bp_reload", 32'(s_ready), 32'h8);
      cyc(0, 4'b0000, 0);
      chk("bp_full", 32'(s_valid), 1);
      chk("bp_src3", 32'(s_src),   3);
      chk("bp_d3",   32'(s_data),  32'h3333);

      // Reset while FULL and granting.
      cyc(0, 4'b1111, 1);
      cyc(0, 4'b1111, 1);
      cyc(1, 4'b1111, 1);
      cyc(0, 4'b1111, 1);
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_gnt",   32'(s_ready), 32'h1);

`ifdef RV_DFF_ARB_LOCK_EN
      cyc(1, 4'b0000, 0);
      lk = 4'b0001; cyc(0, 4'b0011, 1); chk("lock_g0", 32'(s_ready), 32'h1);
      lk = 4'b0001; cyc(0, 4'b0011, 1); chk("lock_g1", 32'(s_ready), 32'h1);
      lk = 4'b0000; cyc(0, 4'b0011, 1); chk("lock_g2", 32'(s_ready), 32'h1);
      lk = 4'b0000; cyc(0, 4'b0011, 1); chk("lock_rel", 32'(s_ready), 32'h2);
`endif

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NREQ; k++) rd[k] = 16'($urandom);
`ifdef RV_DFF_ARB_LOCK_EN
         lk = 4'($urandom_range(0, 15));
`endif
         cyc(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
